// File: rtl/proj_fm_reader_if.sv
// Fragment stream from the FM read sequencer to the MinHash engine.
// The master drives valid/data/pos/last and the slave drives ready.
interface proj_fm_reader_if #(
  parameter int unsigned FRAG_LEN = 64,
  parameter int unsigned IDX_W    = 12
);
  logic                out_valid;
  logic                out_ready;
  logic [FRAG_LEN-1:0] out_frag;
  logic [IDX_W-1:0]    out_pos;
  logic                out_last;

  modport master (
    output out_valid,
    output out_frag,
    output out_pos,
    output out_last,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  out_frag,
    input  out_pos,
    input  out_last,
    output out_ready
  );
endinterface

// File: rtl/proj_fm_reader.sv
// Read-side sequencer for the ping-pong fragment memory: it swaps buffers, sweeps every
// fragment start position, and registers the FM read data into a valid/ready stream.
module proj_fm_reader #(
  parameter int unsigned DATA_BITS         = 2,
  parameter int unsigned FRAG_LEN          = 64,
  parameter int unsigned BUF_ENTRIES       = 1024,
  parameter int unsigned SIGNED_INDICE_LEN = 12
) (
  input  logic                         in_clk,
  input  logic                         in_rst_n,
  input  logic                         fill_done,
  input  logic                         flush,
  input  logic [FRAG_LEN-1:0]          fm_rdata,
  output logic                         chg_idx,
  output logic [SIGNED_INDICE_LEN-1:0] frag_idx,
  output logic                         busy,
  proj_fm_reader_if.master             out_if
);

  localparam int FragSyms = int'(FRAG_LEN / DATA_BITS);
  // Negative start positions give fragments whose head is zero padding.
  localparam logic [SIGNED_INDICE_LEN-1:0] StartIdx = SIGNED_INDICE_LEN'(-(FragSyms - 1));
  localparam logic [SIGNED_INDICE_LEN-1:0] EndIdx   = SIGNED_INDICE_LEN'(BUF_ENTRIES - 1);

  typedef enum logic [2:0] {StIdle, StSwap, StSettle, StSweep, StDrain, StDone} state_e;

  state_e                         state_q;
  logic                           chg_q;
  logic [SIGNED_INDICE_LEN-1:0]   idx_q;
  logic                           valid_q;
  logic [FRAG_LEN-1:0]            frag_q;
  logic [SIGNED_INDICE_LEN-1:0]   pos_q;
  logic                           last_q;
  logic                           load;

  // Output register may take a new fragment when empty or being drained this cycle.
  assign load = !valid_q || out_if.out_ready;

  always_ff @(posedge in_clk or negedge in_rst_n) begin
    if (!in_rst_n) begin
      state_q <= StIdle;
      chg_q   <= 1'b0;
      idx_q   <= '0;
      valid_q <= 1'b0;
      frag_q  <= '0;
      pos_q   <= '0;
      last_q  <= 1'b0;
    end else begin
      chg_q <= 1'b0;
      if (flush) begin
        state_q <= StIdle;
        idx_q   <= '0;
        valid_q <= 1'b0;
        last_q  <= 1'b0;
      end else begin
        unique case (state_q)
          StIdle: begin
            if (fill_done) begin
              chg_q   <= 1'b1;
              state_q <= StSwap;
            end
          end
          StSwap: begin
            idx_q   <= StartIdx;
            state_q <= StSettle;
          end
          StSettle: state_q <= StSweep;
          StSweep: begin
            if (load) begin
              frag_q  <= fm_rdata;
              pos_q   <= idx_q;
              valid_q <= 1'b1;
              if (idx_q == EndIdx) begin
                last_q  <= 1'b1;
                state_q <= StDrain;
              end else begin
                idx_q <= idx_q + SIGNED_INDICE_LEN'(1);
              end
            end
          end
          StDrain: begin
            if (out_if.out_ready) begin
              valid_q <= 1'b0;
              last_q  <= 1'b0;
              state_q <= StDone;
            end
          end
          StDone: begin
            if (fill_done) begin
              chg_q   <= 1'b1;
              state_q <= StSwap;
            end else begin
              state_q <= StIdle;
            end
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

  assign chg_idx          = chg_q;
  assign frag_idx         = idx_q;
  assign busy             = (state_q != StIdle);
  assign out_if.out_valid = valid_q;
  assign out_if.out_frag  = frag_q;
  assign out_if.out_pos   = pos_q;
  assign out_if.out_last  = last_q;

endmodule
